// File: rtl/prop_delay_meter_if.sv
//------------------------------------------------------------------------------
// prop_delay_meter_if
//   Bundles the measurement, stimulus/response and table read-back signals of
//   prop_delay_meter. clk and rst stay plain ports on the module.
//
//   master : sequencer side (drives start/point/stim/resp/read requests)
//   slave  : prop_delay_meter side (drives status, delay and read data)
//
//   Signals
//     start_i, arc_i, slope_idx_i, capa_idx_i  arm one measurement point
//     stim_i, resp_i                           cell input / output, synchronous
//     busy_o, done_o, timeout_o, err_o         status (pulses except busy_o)
//     delay_o                                  last measured delay, held
//     rd_en_i, rd_arc_i, rd_slope_i, rd_capa_i result table read request
//     rd_valid_o, rd_data_o                    read response
//------------------------------------------------------------------------------
interface prop_delay_meter_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             arc_i;
  logic [2:0]       slope_idx_i;
  logic [2:0]       capa_idx_i;
  logic             stim_i;
  logic             resp_i;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic             err_o;
  logic [CNT_W-1:0] delay_o;
  logic             rd_en_i;
  logic             rd_arc_i;
  logic [2:0]       rd_slope_i;
  logic [2:0]       rd_capa_i;
  logic             rd_valid_o;
  logic [CNT_W-1:0] rd_data_o;

  modport master (
    output start_i, arc_i, slope_idx_i, capa_idx_i, stim_i, resp_i,
    output rd_en_i, rd_arc_i, rd_slope_i, rd_capa_i,
    input  busy_o, done_o, timeout_o, err_o, delay_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  start_i, arc_i, slope_idx_i, capa_idx_i, stim_i, resp_i,
    input  rd_en_i, rd_arc_i, rd_slope_i, rd_capa_i,
    output busy_o, done_o, timeout_o, err_o, delay_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/prop_delay_meter.sv
//------------------------------------------------------------------------------
// prop_delay_meter
//   Responder side of the AND2 timing characterization flow. After being armed
//   for one (arc, slope, capa) point it timestamps the first stimulus edge and
//   the first following response edge, in clock cycles, and stores the cycle
//   delay in a 2 x NBSLOPES x NBCAPA result table. Unanswered phases abort
//   after TIMEOUT cycles and store an all-ones sentinel. The table can be read
//   back at any time, one entry per request, with one cycle of latency.
//
//   Parameters
//     CNT_W    width of the delay counter and of the table entries
//     TIMEOUT  maximum cycles spent in each waiting phase (< 2**CNT_W - 1)
//     NBSLOPES slope index range
//     NBCAPA   capa index range
//
//   Ports
//     clk   single clock, all logic on the rising edge
//     rst   synchronous, active-high reset (also clears the table)
//     bus   prop_delay_meter_if.slave, see the interface for the signal list
//------------------------------------------------------------------------------
module prop_delay_meter #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int NBSLOPES = 7,
  parameter int NBCAPA   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  prop_delay_meter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STIM,
    WAIT_RESP,
    STORE
  } state_t;

  // Unmeasured entries and aborted measurements both read as all-ones.
  localparam logic [CNT_W-1:0] SENTINEL = '1;
  // cnt is 0 on entry to a waiting phase, so it holds TIMEOUT-1 on the
  // TIMEOUT-th edge spent there.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  // Bounds widened by one bit so a range of 8 still compares correctly.
  localparam logic [3:0]       NS_LIM   = 4'(NBSLOPES);
  localparam logic [3:0]       NC_LIM   = 4'(NBCAPA);

  state_t           state;
  logic             arc_q;
  logic [2:0]       slope_q;
  logic [2:0]       capa_q;
  logic             stim_base;
  logic             resp_base;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas_q;     // delay captured on the response edge

  logic [CNT_W-1:0] tbl [2][NBSLOPES][NBCAPA];

  logic start_ok;
  logic start_err;
  logic rd_ok;
  logic rd_err;
  logic stim_chg;
  logic resp_chg;
  logic tmo_hit;

  //----------------------------------------------------------------------------
  // Decode of the current inputs against the latched baselines
  //----------------------------------------------------------------------------
  assign start_ok  = ({1'b0, bus.slope_idx_i} < NS_LIM) &&
                     ({1'b0, bus.capa_idx_i}  < NC_LIM);
  // Starts are only looked at in IDLE, so a bad start while busy is silent.
  assign start_err = (state == IDLE) && bus.start_i && !start_ok;

  assign rd_ok     = ({1'b0, bus.rd_slope_i} < NS_LIM) &&
                     ({1'b0, bus.rd_capa_i}  < NC_LIM);
  assign rd_err    = bus.rd_en_i && !rd_ok;

  assign stim_chg  = (bus.stim_i != stim_base);
  assign resp_chg  = (bus.resp_i != resp_base);
  assign tmo_hit   = (cnt == TMO_LAST);

  //----------------------------------------------------------------------------
  // FSM, result table and read port
  //----------------------------------------------------------------------------
  // NOTE: every register here, table included, is assigned with <= so all of
  // them sample the pre-edge values; this is also what makes a read of the
  // entry being written in the same cycle return the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      arc_q         <= 1'b0;
      slope_q       <= '0;
      capa_q        <= '0;
      stim_base     <= 1'b0;
      resp_base     <= 1'b0;
      cnt           <= '0;
      meas_q        <= '0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.timeout_o <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.delay_o   <= '0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_data_o <= '0;
      // NOTE: the table is built from flops rather than a RAM macro because
      // reset must return every entry to the unmeasured sentinel; a RAM
      // could not be cleared in a single cycle.
      for (int a = 0; a < 2; a++) begin
        for (int s = 0; s < NBSLOPES; s++) begin
          for (int c = 0; c < NBCAPA; c++) begin
            tbl[a][s][c] <= SENTINEL;
          end
        end
      end
    end else begin
      // Pulses default low and are raised only by the branch that owns them.
      bus.done_o     <= 1'b0;
      bus.timeout_o  <= 1'b0;
      bus.rd_valid_o <= 1'b0;
      // A start error and a read error in the same cycle merge into one pulse.
      bus.err_o      <= start_err || rd_err;

      // Read port runs independently of the FSM. rd_data_o holds its value
      // across idle cycles and invalid requests.
      if (bus.rd_en_i && rd_ok) begin
        bus.rd_data_o  <= tbl[bus.rd_arc_i][bus.rd_slope_i][bus.rd_capa_i];
        bus.rd_valid_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start_i && start_ok) begin
            arc_q      <= bus.arc_i;
            slope_q    <= bus.slope_idx_i;
            capa_q     <= bus.capa_idx_i;
            stim_base  <= bus.stim_i;
            resp_base  <= bus.resp_i;
            cnt        <= '0;
            bus.busy_o <= 1'b1;
            state      <= WAIT_STIM;
          end
        end

        WAIT_STIM: begin
          if (stim_chg) begin
            cnt <= '0;
            if (resp_chg) begin
              // Both edges seen on the same clock: zero-cycle delay.
              meas_q <= '0;
              state  <= STORE;
            end else begin
              state  <= WAIT_RESP;
            end
          end else if (tmo_hit) begin
            tbl[arc_q][slope_q][capa_q] <= SENTINEL;
            bus.delay_o   <= SENTINEL;
            bus.timeout_o <= 1'b1;
            bus.busy_o    <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            // A response glitch before the stimulus is not a measurement;
            // just track the new level so it is not mistaken for one later.
            if (resp_chg) begin
              resp_base <= bus.resp_i;
            end
          end
        end

        WAIT_RESP: begin
          // Stimulus is no longer looked at: only the first edge counts.
          if (resp_chg) begin
            // cnt lags the edge count by one since it starts at 0 on the
            // stimulus edge itself.
            meas_q <= cnt + 1'b1;
            state  <= STORE;
          end else if (tmo_hit) begin
            tbl[arc_q][slope_q][capa_q] <= SENTINEL;
            bus.delay_o   <= SENTINEL;
            bus.timeout_o <= 1'b1;
            bus.busy_o    <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STORE: begin
          tbl[arc_q][slope_q][capa_q] <= meas_q;
          bus.delay_o <= meas_q;
          bus.done_o  <= 1'b1;
          bus.busy_o  <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prop_delay_meter.sv
//------------------------------------------------------------------------------
// tb_prop_delay_meter
//   Self-checking bench for prop_delay_meter (TIMEOUT shortened to 20).
//   Expected delays come from the edge numbers at which the bench toggles
//   stim/resp; the result table is modelled as a plain 2x7x7 int array.
//------------------------------------------------------------------------------
module tb_prop_delay_meter;

  localparam int CNT_W   = 16;
  localparam int TMO     = 20;
  localparam int UNMEAS  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prop_delay_meter_if #(.CNT_W(CNT_W)) bus ();

  prop_delay_meter #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TMO),
    .NBSLOPES (7),
    .NBCAPA   (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int model [2][7][7];
  int exp_rd = 0;

  typedef struct {
    bit arc;
    int slope;
    int capa;
    int gap;        // idle cycles between start and stimulus edge
    int dly;        // response edge offset from stimulus edge, <0 = never
    bit pre_resp;   // toggle resp once before the stimulus edge
    bit exp_err;    // expected: start rejected with err_o
    int exp_delay;  // expected: stored delay / delay_o
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 2; a++)
      for (int s = 0; s < 7; s++)
        for (int c = 0; c < 7; c++)
          model[a][s][c] = UNMEAS;
  endtask

  // One-cycle read; invalid addresses must raise err_o and leave data alone.
  task automatic rd(input bit a, input int s, input int c);
    bus.rd_en_i    = 1'b1;
    bus.rd_arc_i   = a;
    bus.rd_slope_i = 3'(s);
    bus.rd_capa_i  = 3'(c);
    tick();
    bus.rd_en_i    = 1'b0;
    if (s < 7 && c < 7) begin
      exp_rd = model[a][s][c];
      check("rd_valid", int'(bus.rd_valid_o), 1);
      check("rd_err_low", int'(bus.err_o), 0);
    end else begin
      check("rd_bad_valid", int'(bus.rd_valid_o), 0);
      check("rd_bad_err", int'(bus.err_o), 1);
    end
    check("rd_data", int'(bus.rd_data_o), exp_rd);
  endtask

  task automatic read_all();
    for (int a = 0; a < 2; a++)
      for (int s = 0; s < 7; s++)
        for (int c = 0; c < 7; c++)
          rd(a[0], s, c);
  endtask

  // Full measurement: start, gap cycles, stimulus edge s, response edge r.
  task automatic measure(input bit a, input int s, input int c, input int gap,
                         input int dly, input bit pre_resp, input bit poke,
                         input int exp_d);
    bus.start_i     = 1'b1;
    bus.arc_i       = a;
    bus.slope_idx_i = 3'(s);
    bus.capa_idx_i  = 3'(c);
    tick();
    bus.start_i = 1'b0;
    check("busy_after_start", int'(bus.busy_o), 1);
    for (int i = 0; i < gap; i++) begin
      if (pre_resp && i == 0) bus.resp_i = ~bus.resp_i;
      if (poke) begin
        // Starts while busy, even with a bad index, must be ignored silently.
        bus.start_i     = 1'b1;
        bus.arc_i       = 1'($urandom_range(0, 1));
        bus.slope_idx_i = 3'($urandom_range(0, 7));
        bus.capa_idx_i  = 3'($urandom_range(0, 7));
      end
      tick();
      if (poke) check("err_while_busy", int'(bus.err_o), 0);
    end
    bus.start_i = 1'b0;
    bus.stim_i = ~bus.stim_i;
    if (dly == 0) bus.resp_i = ~bus.resp_i;
    tick();                                    // edge s
    if (dly < 0) begin
      repeat (TMO - 1) tick();
      check("timeout_early", int'(bus.timeout_o), 0);
      check("busy_before_tmo", int'(bus.busy_o), 1);
      tick();
      check("timeout_pulse", int'(bus.timeout_o), 1);
      check("busy_after_tmo", int'(bus.busy_o), 0);
      check("delay_tmo", int'(bus.delay_o), exp_d);
    end else begin
      if (dly > 0) begin
        for (int k = 1; k < dly; k++) begin
          if (k == 1) bus.stim_i = ~bus.stim_i;  // must be ignored
          tick();
        end
        bus.resp_i = ~bus.resp_i;
        tick();                                // edge r
      end
      check("done_early", int'(bus.done_o), 0);
      tick();                                  // edge r+1
      check("done_pulse", int'(bus.done_o), 1);
      check("delay_o", int'(bus.delay_o), exp_d);
      check("busy_after_done", int'(bus.busy_o), 0);
    end
    model[a][s][c] = exp_d;
  endtask

  initial begin
    int d;
    int g;
    bit a;

    bus.start_i = 0; bus.arc_i = 0; bus.slope_idx_i = 0; bus.capa_idx_i = 0;
    bus.stim_i = 0; bus.resp_i = 0;
    bus.rd_en_i = 0; bus.rd_arc_i = 0; bus.rd_slope_i = 0; bus.rd_capa_i = 0;
    model_clear();

    vecs[0] = '{arc:0, slope:2, capa:3, gap:9, dly:4,  pre_resp:0, exp_err:0, exp_delay:4};
    vecs[1] = '{arc:1, slope:0, capa:0, gap:1, dly:0,  pre_resp:0, exp_err:0, exp_delay:0};
    vecs[2] = '{arc:0, slope:6, capa:6, gap:2, dly:13, pre_resp:1, exp_err:0, exp_delay:13};
    vecs[3] = '{arc:1, slope:6, capa:0, gap:0, dly:1,  pre_resp:0, exp_err:0, exp_delay:1};
    vecs[4] = '{arc:0, slope:5, capa:1, gap:3, dly:-1, pre_resp:0, exp_err:0, exp_delay:UNMEAS};
    vecs[5] = '{arc:0, slope:2, capa:7, gap:0, dly:0,  pre_resp:0, exp_err:1, exp_delay:0};
    vecs[6] = '{arc:1, slope:7, capa:1, gap:0, dly:0,  pre_resp:0, exp_err:1, exp_delay:0};

    // Reset state
    tick(); tick();
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_timeout", int'(bus.timeout_o), 0);
    check("rst_err", int'(bus.err_o), 0);
    check("rst_rd_valid", int'(bus.rd_valid_o), 0);
    check("rst_delay", int'(bus.delay_o), 0);
    check("rst_rd_data", int'(bus.rd_data_o), 0);
    rst = 1'b0;
    rd(1'b1, 4, 5);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err) begin
        bus.start_i     = 1'b1;
        bus.arc_i       = vecs[i].arc;
        bus.slope_idx_i = 3'(vecs[i].slope);
        bus.capa_idx_i  = 3'(vecs[i].capa);
        tick();
        bus.start_i = 1'b0;
        check("bad_start_err", int'(bus.err_o), 1);
        check("bad_start_busy", int'(bus.busy_o), 0);
        tick();
        check("bad_start_err_pulse", int'(bus.err_o), 0);
        check("bad_start_busy2", int'(bus.busy_o), 0);
      end else begin
        measure(vecs[i].arc, vecs[i].slope, vecs[i].capa, vecs[i].gap,
                vecs[i].dly, vecs[i].pre_resp, 1'b0, vecs[i].exp_delay);
      end
    end
    rd(1'b0, 2, 3);
    rd(1'b0, 7, 2);

    // Timeout while still waiting for the stimulus
    bus.start_i = 1'b1; bus.arc_i = 1'b1; bus.slope_idx_i = 3'd1; bus.capa_idx_i = 3'd1;
    tick();
    bus.start_i = 1'b0;
    repeat (TMO - 1) tick();
    check("stim_tmo_early", int'(bus.timeout_o), 0);
    tick();
    check("stim_tmo_pulse", int'(bus.timeout_o), 1);
    check("stim_tmo_busy", int'(bus.busy_o), 0);
    check("stim_tmo_delay", int'(bus.delay_o), UNMEAS);
    model[1][1][1] = UNMEAS;
    rd(1'b1, 1, 1);

    // Read of the entry being written in the same cycle returns the old value
    bus.start_i = 1'b1; bus.arc_i = 1'b0; bus.slope_idx_i = 3'd2; bus.capa_idx_i = 3'd3;
    tick();
    bus.start_i = 1'b0;
    bus.stim_i = ~bus.stim_i;
    tick();                                    // edge s
    bus.resp_i = ~bus.resp_i;
    tick();                                    // edge r = s+1
    bus.rd_en_i = 1'b1; bus.rd_arc_i = 1'b0; bus.rd_slope_i = 3'd2; bus.rd_capa_i = 3'd3;
    tick();                                    // edge r+1: write and read
    bus.rd_en_i = 1'b0;
    check("collide_done", int'(bus.done_o), 1);
    check("collide_rd_valid", int'(bus.rd_valid_o), 1);
    check("collide_rd_old", int'(bus.rd_data_o), model[0][2][3]);
    exp_rd = model[0][2][3];
    model[0][2][3] = 1;
    rd(1'b0, 2, 3);

    // Start error and read error together give one err pulse
    bus.start_i = 1'b1; bus.slope_idx_i = 3'd1; bus.capa_idx_i = 3'd7;
    bus.rd_en_i = 1'b1; bus.rd_slope_i = 3'd7; bus.rd_capa_i = 3'd0;
    tick();
    bus.start_i = 1'b0; bus.rd_en_i = 1'b0;
    check("dual_err", int'(bus.err_o), 1);
    check("dual_rd_valid", int'(bus.rd_valid_o), 0);
    check("dual_busy", int'(bus.busy_o), 0);
    tick();
    check("dual_err_pulse", int'(bus.err_o), 0);

    // Sweep: delay = slope + capa + arc over all 98 points
    for (int ai = 0; ai < 2; ai++)
      for (int s = 0; s < 7; s++)
        for (int c = 0; c < 7; c++) begin
          g = int'($urandom_range(0, 3));
          measure(ai[0], s, c, g, s + c + ai, (g > 0) && ($urandom_range(0, 3) == 0),
                  g > 0, s + c + ai);
        end
    read_all();

    // Random overwrites, including some timeouts
    for (int n = 0; n < 30; n++) begin
      int s;
      int c;
      a = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 6));
      c = int'($urandom_range(0, 6));
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 15));
      g = int'($urandom_range(0, 3));
      measure(a, s, c, g, d, (g > 0) && ($urandom_range(0, 1) == 1), 1'b0,
              (d < 0) ? UNMEAS : d);
    end
    read_all();

    // Reset in the middle of WAIT_RESP
    bus.start_i = 1'b1; bus.arc_i = 1'b0; bus.slope_idx_i = 3'd4; bus.capa_idx_i = 3'd4;
    tick();
    bus.start_i = 1'b0;
    bus.stim_i = ~bus.stim_i;
    tick(); tick(); tick();
    check("mid_busy", int'(bus.busy_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", int'(bus.busy_o), 0);
    check("mid_rst_delay", int'(bus.delay_o), 0);
    check("mid_rst_rd_data", int'(bus.rd_data_o), 0);
    model_clear();
    exp_rd = 0;
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
